lut_interp_16: RTL
==================

Name: lut_interp_16

Overview:
- Downstream consumer of the 16-bit function LUT stages (sin_2pi / tanh_4).
- Accepts a Q-format phase/argument on a ready/valid input and holds it on lut_x.
- Issues a single-cycle lut_read, captures base/next/frac on the LUT's lut_valid pulse, and linearly interpolates.
- Presents a rounded signed Q1.15 result on a ready/valid output toward the effect datapath.

Parameters:
- FRAC_WIDTH, 4, fraction width; must equal LUT_FRAC_WIDTH from lut.vh.
- TIMEOUT_CYCLES, 15, max cycles spent in WAIT for lut_valid before abort.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  argument available
- in_ready  out  1  block can accept argument
- in_x  in  16  signed argument
- lut_read  out  1  one-cycle request pulse to LUT
- lut_x  out  16  argument held to LUT x input
- lut_valid  in  1  LUT one-cycle result strobe
- lut_base  in  16  LUT base_sample
- lut_next  in  16  LUT next_sample
- lut_frac  in  FRAC_WIDTH  LUT frac
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_y  out  16  signed interpolated result
- err  out  1  one-cycle pulse on LUT timeout

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, lut_read=0, lut_x=0, out_valid=0, out_y=0, err=0, timeout counter=0.
- Reset mid-operation aborts everything; partial results are discarded. The LUT shares the same reset.

States:
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: lut_x<=in_x; go to REQ.
- REQ:
  - lut_read=1 for exactly this cycle (registered, asserted in the cycle after accept).
  - Go to WAIT; clear the counter.
- WAIT:
  - On lut_valid: register base, next, frac; go to MUL.
  - Otherwise increment the counter.
  - When counter==TIMEOUT_CYCLES-1 with no lut_valid: err pulse for one cycle, go to IDLE, no output produced.
  - lut_x stays stable from accept until MUL is left.
- MUL: prod <= diff*frac, where diff = next-base (17-bit signed) and frac is zero-extended. Go to ADD.
- ADD: out_y <= sat16(base + ((prod + 2^(FRAC_WIDTH-1)) >>> FRAC_WIDTH)); out_valid<=1; go to OUT.
- OUT:
  - Hold out_valid and out_y stable until out_ready.
  - On out_ready: out_valid<=0; go to IDLE.

Rules and boundary conditions:
- in_ready is 0 in every state except IDLE. A single transaction is in flight; there is no overlap.
- lut_valid seen outside WAIT is ignored.
- Arithmetic:
  - All operands are treated as signed, including the tanh unsigned-declared ports.
  - prod width is 22 bits signed; the shift is arithmetic.
  - Rounding is round-half-up.
  - sat16 clamps to [-32768, 32767].
  - frac=0 yields base exactly.
  - base=next yields base.
- Wrap: the sin LUT supplies next=entry0 at index 2047. Treat it as an ordinary pair; a negative diff is handled by signed math.
- Latency:
  - out_valid rises 3 cycles after the cycle lut_valid is high.
  - Total accept-to-out_valid = 2 + LUT latency + 3 cycles.
- If out_ready is already high when out_valid rises, the result is consumed that cycle. in_ready returns the next cycle.

Test Plan:
- base=0x1000, next=0x2000, frac=8 -> out_y=0x1800, out_valid 3 cycles after lut_valid.
- base=0x2000, next=0x1000, frac=4 -> out_y=0x1C00 (negative diff).
- base=0x0000, next=0x0003, frac=8 -> out_y=0x0002 (rounding); frac=0, base=0x8123 -> out_y=0x8123.
- out_ready held low 5 cycles after out_valid -> out_y and out_valid constant, in_ready=0, in_valid ignored; out_ready=1 -> out_valid drops next cycle and in_ready=1.
- lut_valid never asserted -> err pulse exactly TIMEOUT_CYCLES cycles after lut_read, then in_ready=1 and out_valid stays 0.
- reset pulse while in WAIT, then a late lut_valid -> stays IDLE, out_valid=0, no err; a following in_x=0x4000 against the real sin_2pi LUT -> out_y matches the lut_base/lut_next interpolation.

Source files
------------

// File: rtl/lut_interp_16.sv
// Purpose : fetches a base/next/frac triple from a 16-bit function LUT and
//           linearly interpolates it into a rounded, saturated Q1.15 sample.
// Latency : accept -> lut_read 1 cycle; lut_valid -> out_valid 3 cycles.
// Backpressure: one transaction in flight; in_ready low outside IDLE and the
//           result is held on out_y/out_valid until out_ready.
// Ports   : in_valid/in_ready/in_x   argument handshake
//           lut_read/lut_x            request pulse and held argument to LUT
//           lut_valid/base/next/frac  LUT result strobe and data
//           out_valid/out_ready/out_y interpolated result handshake
//           err                       one-cycle pulse when the LUT never answers
module lut_interp_16 #(
    parameter int FRAC_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_x,
    output logic                  lut_read,
    output logic [15:0]           lut_x,
    input  logic                  lut_valid,
    input  logic [15:0]           lut_base,
    input  logic [15:0]           lut_next,
    input  logic [FRAC_WIDTH-1:0] lut_frac,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_y,
    output logic                  err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MUL  = 3'd3;
    localparam logic [2:0] S_ADD  = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    // 17-bit signed diff times (FRAC_WIDTH+1)-bit zero-extended frac
    localparam int PROD_W = 17 + FRAC_WIDTH + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic signed [PROD_W:0] HALF =
        {{(PROD_W + 1 - FRAC_WIDTH){1'b0}}, 1'b1, {(FRAC_WIDTH - 1){1'b0}}};
    localparam logic signed [PROD_W+1:0] Y_MAX = (PROD_W + 2)'(32767);
    localparam logic signed [PROD_W+1:0] Y_MIN = -(PROD_W + 2)'(32768);

    logic [2:0]               state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic                     lut_read_q, lut_read_d;
    logic [15:0]              lut_x_q, lut_x_d;
    logic [15:0]              base_q, base_d;
    logic [15:0]              next_q, next_d;
    logic [FRAC_WIDTH-1:0]    frac_q, frac_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     out_valid_q, out_valid_d;
    logic [15:0]              out_y_q, out_y_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic                     timeout_hit;
    logic signed [16:0]       diff;
    logic signed [PROD_W-1:0] mul;
    logic signed [PROD_W:0]   rnd;
    logic signed [PROD_W:0]   shifted;
    logic signed [PROD_W+1:0] sum;
    logic [15:0]              sat_y;

    // Datapath: all LUT samples are interpreted as signed, whatever the LUT
    // declares. The wrap pair at the end of the sin table just gives a
    // negative diff.
    always_comb begin
        diff    = $signed({next_q[15], next_q}) - $signed({base_q[15], base_q});
        mul     = PROD_W'(diff) * PROD_W'($signed({1'b0, frac_q}));
        rnd     = $signed({prod_q[PROD_W-1], prod_q}) + HALF;
        shifted = rnd >>> FRAC_WIDTH;
        sum     = $signed({{(PROD_W - 14){base_q[15]}}, base_q})
                + $signed({shifted[PROD_W], shifted});
        if (sum > Y_MAX) begin
            sat_y = 16'h7FFF;
        end else if (sum < Y_MIN) begin
            sat_y = 16'h8000;
        end else begin
            sat_y = sum[15:0];
        end
    end

    assign timeout_hit = (state_q == S_WAIT) && !lut_valid && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        lut_read_d  = 1'b0;
        lut_x_d     = lut_x_q;
        base_d      = base_q;
        next_d      = next_q;
        frac_d      = frac_q;
        prod_d      = prod_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    lut_x_d    = in_x;
                    lut_read_d = 1'b1;   // lands in the REQ cycle
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lut_valid) begin
                    base_d  = lut_base;
                    next_d  = lut_next;
                    frac_d  = lut_frac;
                    state_d = S_MUL;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MUL: begin
                prod_d  = mul;
                state_d = S_ADD;
            end
            S_ADD: begin
                out_y_d     = sat_y;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Registered ready: it follows the state we are about to enter
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            lut_read_q  <= 1'b0;
            lut_x_q     <= '0;
            base_q      <= '0;
            next_q      <= '0;
            frac_q      <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            lut_read_q  <= lut_read_d;
            lut_x_q     <= lut_x_d;
            base_q      <= base_d;
            next_q      <= next_d;
            frac_q      <= frac_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign lut_read  = lut_read_q;
    assign lut_x     = lut_x_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    // Combinational so the pulse lands in the last WAIT cycle, exactly
    // TIMEOUT_CYCLES cycles after lut_read
    assign err       = timeout_hit && !reset;

endmodule
